// File: rtl/otter_pkg.sv
// Shared encodings for the OTTER control unit: FSM state type plus the
// opcode and func3 values the decoder recognises.
package otter_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_MRET  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;

endpackage

// File: rtl/cu_fsm.sv
// OTTER multicycle control FSM: INIT -> FETCH -> EXEC [-> WB] [-> INTR].
// Outputs are Moore on state, plus Mealy decode of opcode/func3 in EXEC.
module cu_fsm
  import otter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       intr,
  input  logic       mie,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_we2,
  output logic       mem_rden1,
  output logic       mem_rden2,
  output logic       reset_out,
  output logic       csr_we,
  output logic       int_taken
);

  state_t state;
  state_t next_state;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= next_state;
  end

  always_comb begin
    next_state = ST_INIT;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_we2    = 1'b0;
    mem_rden1  = 1'b0;
    mem_rden2  = 1'b0;
    reset_out  = 1'b0;
    csr_we     = 1'b0;
    int_taken  = 1'b0;

    unique case (state)
      ST_INIT: begin
        reset_out  = 1'b1;
        next_state = ST_FETCH;
      end

      ST_FETCH: begin
        mem_rden1  = 1'b1;
        next_state = ST_EXEC;
      end

      ST_EXEC: begin
        // Interrupts are only taken at instruction boundaries; loads defer to WB.
        next_state = (intr && mie) ? ST_INTR : ST_FETCH;
        case (opcode)
          OPC_LOAD: begin
            mem_rden2  = 1'b1;
            next_state = ST_WB;
          end
          OPC_STORE: begin
            mem_we2  = 1'b1;
            pc_write = 1'b1;
          end
          OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
            pc_write  = 1'b1;
            reg_write = 1'b1;
          end
          OPC_SYSTEM: begin
            pc_write = 1'b1;
            if (func3 == F3_CSRRW) begin
              reg_write = 1'b1;
              csr_we    = 1'b1;
            end
          end
          default: pc_write = 1'b1;
        endcase
      end

      ST_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        next_state = (intr && mie) ? ST_INTR : ST_FETCH;
      end

      ST_INTR: begin
        int_taken  = 1'b1;
        pc_write   = 1'b1;
        next_state = ST_FETCH;
      end

      default: next_state = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_cu_fsm.sv
// Instruction-level bench for cu_fsm: each instruction expands into its
// expected per-cycle output words, which are compared against the DUT.
module tb_cu_fsm;

  logic       clk;
  logic       rst;
  logic       intr;
  logic       mie;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       pc_write, reg_write, mem_we2, mem_rden1, mem_rden2;
  logic       reset_out, csr_we, int_taken;

  int n_cmp = 0;
  int n_err = 0;

  cu_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .intr      (intr),
    .mie       (mie),
    .opcode    (opcode),
    .func3     (func3),
    .pc_write  (pc_write),
    .reg_write (reg_write),
    .mem_we2   (mem_we2),
    .mem_rden1 (mem_rden1),
    .mem_rden2 (mem_rden2),
    .reset_out (reset_out),
    .csr_we    (csr_we),
    .int_taken (int_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, reset_out, csr_we, int_taken}
  localparam logic [7:0] W_INIT  = 8'b0000_0100;
  localparam logic [7:0] W_FETCH = 8'b0001_0000;
  localparam logic [7:0] W_WB    = 8'b1100_0000;
  localparam logic [7:0] W_INTR  = 8'b1000_0001;
  localparam logic [7:0] W_PC    = 8'b1000_0000;
  localparam logic [7:0] W_PCREG = 8'b1100_0000;

  logic [7:0] outs;
  assign outs = {pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, reset_out, csr_we, int_taken};

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exec_word(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0000011: return 8'b0000_1000;
      7'b0100011: return 8'b1010_0000;
      7'b1100011: return W_PC;
      7'b0110011, 7'b0010011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100111: return W_PCREG;
      7'b1110011: return (f3 == 3'b001) ? 8'b1100_0010 : W_PC;
      default:    return W_PC;
    endcase
  endfunction

  // rst_at: index of the cycle in which rst is raised (-1 for none)
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic irq, input logic en, input int rst_at);
    logic [7:0] exp_q[$];
    int exit_idx;
    int n;
    exp_q.push_back(W_FETCH);
    exp_q.push_back(exec_word(op, f3));
    if (op == 7'b0000011) exp_q.push_back(W_WB);
    exit_idx = exp_q.size() - 1;
    if (irq && en) exp_q.push_back(W_INTR);
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      opcode = op;
      func3  = f3;
      intr   = (k == exit_idx) ? irq : 1'($urandom_range(0, 1));
      mie    = (k == exit_idx) ? en  : 1'($urandom_range(0, 1));
      rst    = (k == rst_at);
      #1;
      check_eq(tag, outs, exp_q[k]);
      check_eq("excl", {6'b0, mem_we2 & mem_rden2, reg_write & int_taken}, 8'h00);
      if (k == rst_at) begin
        @(posedge clk); #1;
        rst  = 1'b0;
        intr = 1'($urandom_range(0, 1));
        #1;
        check_eq("rst_init", outs, W_INIT);
        return;
      end
    end
  endtask

  initial begin
    logic [6:0] ops [11];
    logic [6:0] op;
    ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011, 7'b0010011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011, 7'b1111111};
    rst = 1'b1; intr = 1'b0; mie = 1'b0; opcode = '0; func3 = '0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check_eq("reset_hold", outs, W_INIT);
    end
    rst = 1'b0;
    #1;
    check_eq("reset_init", outs, W_INIT);

    run_instr("load",       7'b0000011, 3'b010, 1'b0, 1'b0, -1);
    run_instr("store_irq",  7'b0100011, 3'b010, 1'b1, 1'b1, -1);
    run_instr("store_irq2", 7'b0100011, 3'b010, 1'b1, 1'b1, -1);
    run_instr("op_nomie",   7'b0110011, 3'b000, 1'b1, 1'b0, -1);
    run_instr("csrrw",      7'b1110011, 3'b001, 1'b0, 1'b0, -1);
    run_instr("mret",       7'b1110011, 3'b000, 1'b0, 1'b0, -1);
    run_instr("illegal",    7'b1111111, 3'b111, 1'b0, 1'b0, -1);
    run_instr("load_irq",   7'b0000011, 3'b010, 1'b1, 1'b1, -1);
    run_instr("load_rstwb", 7'b0000011, 3'b010, 1'b0, 1'b0, 2);
    run_instr("jal_rstint", 7'b1101111, 3'b000, 1'b1, 1'b1, 2);

    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 4) == 0) ? 7'($urandom) : ops[$urandom_range(0, 10)];
      run_instr("rand", op, 3'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/cu_fsm.md
CU_FSM -- requirements
Module: cu_fsm

Interface
REQ-001 Parameters: none; all encodings come from the shared package.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 intr  input  1  external interrupt request, level-sensitive, synchronous to clk.
REQ-005 mie  input  1  interrupt enable from CSR file (mstatus.MIE).
REQ-006 opcode  input  7  ir[6:0] of the current instruction.
REQ-007 func3  input  3  ir[14:12] of the current instruction.
REQ-008 pc_write  output  1  PC register load enable.
REQ-009 reg_write  output  1  register-file write enable.
REQ-010 mem_we2  output  1  data-port write enable.
REQ-011 mem_rden1  output  1  instruction-port read enable.
REQ-012 mem_rden2  output  1  data-port read enable.
REQ-013 reset_out  output  1  PC / CSR reset strobe.
REQ-014 csr_we  output  1  CSR write enable.
REQ-015 int_taken  output  1  interrupt-entry strobe to CSR file and PC mux.

Function
REQ-016 States: INIT, FETCH, EXEC, WB, INTR; binary-encoded state register.
REQ-017 Outputs SHALL be combinational from state (Moore), plus opcode/func3 in EXEC (Mealy); default 0 for every output in every state unless stated.
REQ-018 INIT: reset_out=1; next FETCH unconditionally.
REQ-019 FETCH: mem_rden1=1; next EXEC.
REQ-020 EXEC, LOAD (0000011): mem_rden2=1, pc_write=0, reg_write=0; next WB.
REQ-021 EXEC, STORE (0100011): mem_we2=1, pc_write=1.
REQ-022 EXEC, BRANCH (1100011): pc_write=1 only.
REQ-023 EXEC, OP (0110011), OP_IMM (0010011), LUI (0110111), AUIPC (0010111), JAL (1101111), JALR (1100111): pc_write=1, reg_write=1.
REQ-024 EXEC, SYSTEM (1110011) func3=001 (CSRRW): pc_write=1, reg_write=1, csr_we=1; func3=000 (MRET): pc_write=1 only; other func3: pc_write=1 only.
REQ-025 EXEC, any unlisted opcode: pc_write=1 only (executed as NOP); FSM SHALL never stall or lock up.
REQ-026 WB: reg_write=1, pc_write=1.
REQ-027 Exit from EXEC (non-load) or WB: next INTR if (intr & mie), else FETCH.
REQ-028 Interrupts SHALL be sampled only at the EXEC/WB exit edge; intr in FETCH/INIT/INTR is ignored until the next exit.
REQ-029 INTR: int_taken=1, pc_write=1, all memory/register enables 0; next FETCH unconditionally (no back-to-back INTR).
REQ-030 Every instruction completes in 3 cycles (FETCH, EXEC, WB) for LOAD and 2 cycles otherwise; interrupt entry adds exactly 1 cycle.
REQ-031 mem_we2 and mem_rden2 SHALL never both be 1; reg_write and int_taken SHALL never both be 1.

Reset
REQ-032 rst=1 at a rising edge SHALL force state to INIT from any state, including mid-LOAD (WB) and INTR.
REQ-033 While rst is held, state remains INIT: reset_out=1, all other outputs 0.
REQ-034 After rst deasserts, exactly one INIT cycle precedes the first FETCH.

Structure
REQ-035 Shared package otter_pkg SHALL hold the state enum typedef and the opcode/func3 localparams; the decoder uses the same package.
REQ-036 No sub-module; one sequential state-register process plus one combinational next-state/output process.

Verification
REQ-037 rst high 3 cycles then low -> reset_out=1 for 4 cycles (3 held plus 1 INIT), then mem_rden1=1 on cycle 5.
REQ-038 opcode=0000011 -> FETCH (mem_rden1), EXEC (mem_rden2=1, pc_write=0), WB (reg_write=1, pc_write=1), then FETCH.
REQ-039 opcode=0100011 with intr=1, mie=1 held -> EXEC (mem_we2=1, pc_write=1), INTR (int_taken=1, pc_write=1), FETCH; next EXEC exit re-enters INTR.
REQ-040 intr=1, mie=0 on an OP instruction -> no INTR; EXEC reg_write=1, pc_write=1, then FETCH.
REQ-041 SYSTEM func3=001 -> csr_we=1, reg_write=1; func3=000 -> pc_write=1, csr_we=0; opcode=1111111 -> pc_write=1 only.
REQ-042 rst asserted during WB of a LOAD -> next cycle INIT, reg_write=0, reset_out=1; no write-back occurs.
